// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial front end for the serial adder: takes an operand pair
// plus a bit length and streams both operands LSB-first, one bit per cycle.
module serial_operand_serializer #(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [W-1:0]  up_a,
    input  logic [W-1:0]  up_b,
    input  logic [LW-1:0] up_len,
    output logic          vld,
    output logic          a,
    output logic          b,
    output logic          last
);

    localparam logic [LW-1:0] LEN_MAX = LW'(W);

    logic          vld_q, vld_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic          last_q, last_d;
    logic [W-2:0]  sh_a_q, sh_a_d;
    logic [W-2:0]  sh_b_q, sh_b_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic [LW-1:0] eff_len;

    // Ready depends only on registered state, so there is no up_vld -> up_rdy path.
    assign up_rdy  = !vld_q || last_q;
    assign accept  = up_vld && up_rdy;
    assign eff_len = (up_len == '0 || up_len > LEN_MAX) ? LEN_MAX : up_len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
            last_q <= 1'b0;
            sh_a_q <= '0;
            sh_b_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            a_q    <= a_d;
            b_q    <= b_d;
            last_q <= last_d;
            sh_a_q <= sh_a_d;
            sh_b_q <= sh_b_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // vld_q is the state: 0 = IDLE, 1 = SHIFT.
    always_comb begin
        vld_d  = vld_q;
        a_d    = a_q;
        b_d    = b_q;
        last_d = last_q;
        sh_a_d = sh_a_q;
        sh_b_d = sh_b_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (accept) begin
            vld_d  = 1'b1;
            a_d    = up_a[0];
            b_d    = up_b[0];
            sh_a_d = up_a[W-1:1];
            sh_b_d = up_b[W-1:1];
            len_d  = eff_len;
            cnt_d  = '0;
            last_d = (eff_len == LW'(1));
        end else if (vld_q && !last_q) begin
            a_d    = sh_a_q[0];
            b_d    = sh_b_q[0];
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q + LW'(1);
            // The bit being loaded has index cnt_q+1; it is final when that equals len-1.
            last_d = ((cnt_q + LW'(2)) == len_q);
        end else if (vld_q) begin
            vld_d  = 1'b0;
            a_d    = 1'b0;
            b_d    = 1'b0;
            last_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        vld  = vld_q;
        a    = a_q;
        b    = b_q;
        last = last_q;
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Scoreboard bench for serial_operand_serializer with a behavioural serial adder
// observing the serial stream.
module tb_serial_operand_serializer;

    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          up_vld = 1'b0;
    logic          up_rdy;
    logic [W-1:0]  up_a = '0;
    logic [W-1:0]  up_b = '0;
    logic [LW-1:0] up_len = '0;
    logic          vld, a, b, last;

    serial_operand_serializer #(.W(W), .LW(LW)) dut (
        .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
        .up_a(up_a), .up_b(up_b), .up_len(up_len),
        .vld(vld), .a(a), .b(b), .last(last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic       carry = 1'b0;
    logic [7:0] sum_acc = '0;
    int         sidx = 0;
    logic [7:0] last_sum = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tl);
        int l;
        exp_t e;
        l = (tl == 0 || tl > W) ? W : int'(tl);
        for (int i = 0; i < l; i++) begin
            e.a    = ta[i];
            e.b    = tb_[i];
            e.last = (i == l - 1);
            q.push_back(e);
        end
    endtask

    // Offer a word and return 1ns after the accepting edge (bit 0 then visible).
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tl);
        int n;
        n = 0;
        up_a   = ta;
        up_b   = tb_;
        up_len = tl;
        up_vld = 1'b1;
        while (!up_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!up_rdy) chk("send timeout up_rdy", 32'(up_rdy), 32'd1);
        push_word(ta, tb_, tl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        up_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected bit per vld cycle and feeds the adder model.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic       s;
        logic [7:0] nxt;
        if (!rst) begin
            carry   <= 1'b0;
            sum_acc <= '0;
            sidx    <= 0;
        end else if (vld) begin
            if (q.size() == 0) begin
                chk("unexpected serial bit {a,b,last}", {29'd0, a, b, last}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("serial bit {a,b,last}", {29'd0, a, b, last}, {29'd0, e.a, e.b, e.last});
            end
            s   = a ^ b ^ carry;
            nxt = sum_acc;
            nxt[sidx[2:0]] = s;
            if (last) begin
                last_sum <= nxt;
                sum_acc  <= '0;
                carry    <= 1'b0;
                sidx     <= 0;
            end else begin
                sum_acc <= nxt;
                carry   <= (a & b) | (carry & (a ^ b));
                sidx    <= sidx + 1;
            end
        end
    end

    initial begin
        #12;
        chk("reset vld", 32'(vld), 0);
        chk("reset last", 32'(last), 0);
        chk("reset a/b", {30'd0, a, b}, 0);
        chk("reset up_rdy", 32'(up_rdy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Length 4, ready pattern 0,0,0,1
        send(8'h09, 8'h05, 4'd4);
        up_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("len4 up_rdy", 32'(up_rdy), (i == 3) ? 32'd1 : 32'd0);
            chk("len4 vld", 32'(vld), 1);
            @(posedge clk);
            #1;
        end
        chk("len4 idle after last", 32'(vld), 0);
        chk("len4 a/b zero when idle", {30'd0, a, b}, 0);

        // Length 0 and out-of-range length both mean full width
        send(8'hA5, 8'hFF, 4'd0);
        idle_cycles(10);
        chk("len0 done", 32'(vld), 0);
        send(8'hA5, 8'hFF, 4'd13);
        idle_cycles(10);
        chk("len13 done", 32'(vld), 0);

        // Back-to-back with no bubble
        send(8'h03, 8'h00, 4'd2);
        send(8'h05, 8'h02, 4'd3);
        up_vld = 1'b0;
        chk("b2b word2 bit0 vld", 32'(vld), 1);
        chk("b2b word2 bit0 last", 32'(last), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b word2 last", 32'(last), 1);
        idle_cycles(1);
        chk("b2b idle", 32'(vld), 0);
        idle_cycles(2);

        // Single-bit word
        send(8'h01, 8'h01, 4'd1);
        up_vld = 1'b0;
        chk("len1 vld", 32'(vld), 1);
        chk("len1 last", 32'(last), 1);
        chk("len1 up_rdy", 32'(up_rdy), 1);
        idle_cycles(1);
        chk("len1 idle", 32'(vld), 0);
        chk("len1 up_rdy idle", 32'(up_rdy), 1);

        // Hold while busy: upstream data churns, only the accepted value is sent
        send(8'h3C, 8'h81, 4'd8);
        up_vld = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("hold up_rdy busy", 32'(up_rdy), 0);
            up_a = 8'(i * 37 + 1);
            up_b = 8'(i * 91 + 3);
        end
        @(negedge clk);
        chk("hold last before accept", 32'(last), 1);
        chk("hold up_rdy at last", 32'(up_rdy), 1);
        up_a   = 8'h5A;
        up_b   = 8'hC3;
        up_len = 4'd4;
        push_word(8'h5A, 8'hC3, 4'd4);
        @(posedge clk);
        #1;
        up_vld = 1'b0;
        chk("hold word2 started", 32'(vld), 1);
        idle_cycles(6);

        // Asynchronous reset mid-word
        send(8'hFF, 8'h0F, 4'd8);
        up_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst vld", 32'(vld), 0);
        chk("async rst last", 32'(last), 0);
        chk("async rst a/b", {30'd0, a, b}, 0);
        chk("async rst up_rdy", 32'(up_rdy), 1);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst up_rdy", 32'(up_rdy), 1);
        send(8'h06, 8'h03, 4'd3);
        idle_cycles(5);

        // Serial adder integration: 0x0B + 0x06 = 0x11
        send(8'h0B, 8'h06, 4'd8);
        idle_cycles(10);
        chk("adder sum", 32'(last_sum), 32'h11);

        chk("scoreboard drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/serial_operand_serializer.md
Name: serial_operand_serializer

Overview:
Parallel-to-serial front end for the serial adder with valid. It accepts a pair of operands plus a bit length over a valid/ready handshake. It then streams the operands LSB-first as one bit per cycle on vld/a/b, and flags the final bit with last. Its outputs connect directly to the serial adder's vld, a, b and last inputs. The adder has no backpressure, so this block never stalls mid-word.

Parameters:
W, 8, operand width in bits (W >= 2)
LW, $clog2(W+1), width of the length field

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous assert, active-low (0 = reset)
up_vld  input  1  upstream offers an operand pair
up_rdy  output  1  block can accept an operand pair this cycle
up_a  input  W  operand A, bit 0 is transmitted first
up_b  input  W  operand B, bit 0 is transmitted first
up_len  input  LW  number of bits to send (0 or >W means W)
vld  output  1  serial bit valid
a  output  1  serial bit of A
b  output  1  serial bit of B
last  output  1  final bit of the current word, qualified by vld

Behaviour:
- Reset (rst=0, asynchronous):
  - vld=0, a=0, b=0, last=0.
  - Shift registers and bit counter are cleared.
  - up_rdy=1 (derived from vld/last).
- States:
  - IDLE (vld=0).
  - SHIFT (vld=1).
  - State is encoded by the vld register; there is no separate state register.
- up_rdy = !vld || last, combinational from registered outputs only. There is no combinational path from up_vld.
- Accept: at the rising edge where up_vld && up_rdy:
  - Effective length is L = (up_len==0 || up_len>W) ? W : up_len.
  - Register up_a, up_b and L.
  - Next cycle: vld=1, a=up_a[0], b=up_b[0], last=(L==1).
- Latency: the first serial bit is visible the cycle after the accepting edge.
- SHIFT step, each edge without accept:
  - Drive bit k+1 of both operands; bit counter increments.
  - last=1 exactly when the driven bit index is L-1.
- End of word: the edge after last=1 with no accept → vld=0, last=0, a=0, b=0 (IDLE).
- Back-to-back: up_vld=1 during the last=1 cycle accepts the next word on that edge. Its bit 0 follows with no bubble, and vld stays 1.
- up_vld while busy (vld=1, last=0): up_rdy=0, no accept. Operands are neither sampled nor lost; the upstream must hold them.
- a/b are forced to 0 whenever vld=0.
- The counter holds values 0..W-1 and does not wrap within a word.
- Operand bits at index >= L are never transmitted.
- Reset mid-word drops the in-flight word immediately. No partial last is emitted. The first cycle after reset release shows up_rdy=1.
- No stalls: once accepted, a word emits exactly L consecutive vld=1 cycles.

Test Plan:
- W=8, up_len=4, up_a=8'h09, up_b=8'h05, single handshake:
  - vld=1 for 4 cycles; a=1,0,0,1 and b=1,0,1,0.
  - last=1 only on the 4th cycle, then vld=0.
  - up_rdy=0 on cycles 1-3 and =1 on cycle 4.
- up_len=0, up_a=8'hA5, up_b=8'hFF:
  - 8 bits emitted; a=1,0,1,0,0,1,0,1 and b all 1.
  - last on the 8th bit.
  - Repeat with up_len=13: identical result.
- Back-to-back: word1 (len=2, a=2'b11, b=0) then word2 (len=3, a=3'b101, b=3'b010), with up_vld held high:
  - vld=1 for 5 consecutive cycles; a=1,1,1,0,1 and b=0,0,0,1,0.
  - last on cycles 2 and 5.
- up_len=1, a=1, b=1:
  - One cycle with vld=1, a=1, b=1, last=1; up_rdy=1 throughout.
- Hold while busy: up_a changes every cycle during an 8-bit word:
  - Serialized bits match the value present at the accepting edge.
  - The next word is accepted only at the last=1 edge.
- Reset mid-word: assert rst=0 after bit 3 of an 8-bit word:
  - vld, last, a and b go to 0 without waiting for clk.
  - After release, up_rdy=1 and a new word len=3 serializes correctly.
- Integration with the serial adder, driving its vld/a/b/last:
  - up_a=8'h0B and up_b=8'h06 with len=8 yield serial sum bits 1,0,0,0,1,0,0,0 (0x11).
